imem_fetch_ctrl: RTL and testbench
==================================

# imem_fetch_ctrl

Instruction-fetch sequencer that owns the program counter and drives the 64-word instruction memory's byte read address. Each cycle it reads one word combinationally, captures {pc, instruction} into a 2-entry fetch buffer and presents it to the decode stage over a valid/ready handshake. It also handles branch/jump redirects with flush, end-of-program detection and misaligned-target faults. Sits between the PC/branch logic and the IF/ID boundary.

## Interface
- IMEM_WORDS, 64, instruction memory depth in 32-bit words; valid byte range is 0 .. IMEM_WORDS*4-1
- RESET_PC, 32'h0000_0000, PC loaded on reset
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous, active-low reset
- imem_addr  out  32  byte read address to instruction memory; equals the PC register
- imem_instr  in  32  instruction word returned combinationally for imem_addr
- redirect_valid  in  1  branch/jump taken this cycle
- redirect_pc  in  32  byte target of the redirect
- out_valid  out  1  out_* holds a fetched instruction
- out_ready  in  1  decode accepts; transfer when out_valid && out_ready
- out_instr  out  32  fetched instruction
- out_pc  out  32  byte address of out_instr
- out_pc4  out  32  out_pc + 4
- halted  out  1  PC past memory end and buffer empty
- fault  out  1  sticky: misaligned redirect target received

## Operation
- FSM states: RUN, END, FAULT. Reset enters RUN.
- RUN: a push occurs when count < 2, independent of out_ready, so there is no ready-to-address combinational path. A push writes {pc, imem_instr} and sets pc <= pc + 4.
- RUN -> END when the pc register is >= IMEM_WORDS*4. No pushes occur in END. The buffer keeps draining. halted = (state == END) && count == 0.
- Pop: on out_valid && out_ready, the head entry is removed. Push and pop in the same cycle leave count unchanged.
- Redirect in RUN or END with redirect_pc[1:0] == 0:
  - buffer is flushed (count <= 0)
  - pc <= redirect_pc
  - no push that cycle
  - state <= RUN
  - a handshake completing in the same cycle still counts as delivered
- Redirect with redirect_pc[1:0] != 0: state <= FAULT, fault <= 1, buffer flushed, pc unchanged.
- FAULT: absorbing until reset. No fetch, out_valid = 0, redirects are ignored.
- Redirect has priority over push. The flush takes priority over any pop bookkeeping.
- PC arithmetic is 32-bit unsigned. Wrap-around cannot occur, because END is entered first.
- out_* reflect the buffer head. When out_valid = 0 they hold their last value (zero after reset).

## Timing
- Reset values:
  - pc = imem_addr = RESET_PC
  - out_valid = 0; out_instr, out_pc and out_pc4 = 0
  - halted = 0, fault = 0, count = 0, state = RUN
- Asynchronous reset mid-operation clears everything immediately. The first push after deassertion happens at the first rising edge.
- Fetch latency: a word addressed in cycle N appears on out_* with out_valid = 1 in cycle N+1.
- Throughput: with out_ready held high, 1 instruction/cycle; steady state count = 1.
- With out_ready low, the buffer fills in 2 cycles and pc then stalls. On the cycle ready rises, the head pops, and the push resumes the following cycle.
- Redirect at edge N: out_valid = 0 in cycle N+1, and the target instruction is valid in cycle N+2 (2-cycle bubble).
- END: after the last in-range push, halted rises the cycle after the final pop.
- fault rises in the cycle after the misaligned redirect edge.

## Structure
- Shared package fetch_pkg:
  - state enum ST_RUN/ST_END/ST_FAULT
  - fetch_entry_t struct {pc[31:0], instr[31:0]}
  - constants INSTR_BYTES = 4 and FETCH_BUF_DEPTH = 2
- Sub-module fetch_buf2: a 2-entry FIFO of fetch_entry_t with push, pop, flush, count[1:0] and head outputs. Flush has priority over push and pop.
- The top level holds the PC register, the FSM and the halted/fault flags.

## Test plan
- Reset, program 0x00..0x0C, out_ready = 1 -> out_pc = 0, 4, 8, C on consecutive cycles starting one cycle after reset release; out_pc4 = pc + 4; instructions match memory.
- out_ready = 0 for 5 cycles after reset -> count saturates at 2 and imem_addr stays at 0x8. Raise ready -> out_pc sequence 0, 4, 8 with no loss or duplication.
- Redirect to 0x20 while out_pc = 0x4 is being accepted -> 0x4 delivered; out_valid = 0 for one cycle; next out_pc = 0x20.
- IMEM_WORDS = 64, ready = 1, no redirects -> the last out_pc is 0xFC, then halted = 1 one cycle later. A later redirect to 0x10 clears halted and resumes at 0x10.
- Redirect to 0x22 -> fault = 1 and out_valid = 0 permanently. A further redirect to 0x0 is ignored; only rst_n low clears fault.
- Assert rst_n low asynchronously mid-stream with the buffer full -> out_valid and count clear at once, without waiting for an edge; imem_addr = RESET_PC.

Source files
------------

// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction-fetch sequencer.
package fetch_pkg;

  localparam int INSTR_BYTES     = 4;
  localparam int FETCH_BUF_DEPTH = 2;

  typedef enum logic [1:0] {
    ST_RUN   = 2'd0,
    ST_END   = 2'd1,
    ST_FAULT = 2'd2
  } fetch_state_e;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
  } fetch_entry_t;

endpackage

// File: rtl/fetch_buf2.sv
// Two-entry FIFO of {pc, instr} fetch entries; flush wins over push and pop.
module fetch_buf2
  import fetch_pkg::*;
(
  input  logic         clk,
  input  logic         rst_n,
  input  logic         push_i,
  input  logic         pop_i,
  input  logic         flush_i,
  input  fetch_entry_t data_i,
  output logic [1:0]   count_o,
  output fetch_entry_t head_o
);

  fetch_entry_t mem_q [FETCH_BUF_DEPTH];
  logic         wr_ptr_q;
  logic         rd_ptr_q;
  logic [1:0]   count_q;
  logic         push_ok;
  logic         pop_ok;

  assign push_ok = push_i && (count_q != 2'(FETCH_BUF_DEPTH));
  assign pop_ok  = pop_i && (count_q != 2'd0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
      count_q  <= 2'd0;
    end else if (flush_i) begin
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
      count_q  <= 2'd0;
    end else begin
      if (push_ok) wr_ptr_q <= ~wr_ptr_q;
      if (pop_ok)  rd_ptr_q <= ~rd_ptr_q;
      case ({push_ok, pop_ok})
        2'b10:   count_q <= count_q + 2'd1;
        2'b01:   count_q <= count_q - 2'd1;
        default: count_q <= count_q;
      endcase
    end
  end

  // Payload storage needs no reset; the count qualifies every read.
  always_ff @(posedge clk) begin
    if (push_ok && !flush_i) mem_q[wr_ptr_q] <= data_i;
  end

  assign count_o = count_q;
  assign head_o  = mem_q[rd_ptr_q];

endmodule

// File: rtl/imem_fetch_ctrl.sv
// Instruction-fetch sequencer: PC register, run/end/fault FSM and a 2-entry
// fetch buffer presenting {pc, instr} to decode over valid/ready.
module imem_fetch_ctrl
  import fetch_pkg::*;
#(
  parameter int          IMEM_WORDS = 64,
  parameter logic [31:0] RESET_PC   = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_instr,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_instr,
  output logic [31:0] out_pc,
  output logic [31:0] out_pc4,
  output logic        halted,
  output logic        fault
);

  localparam logic [31:0] PC_LIMIT = 32'(IMEM_WORDS * INSTR_BYTES);

  fetch_state_e state_q, state_d;
  logic [31:0]  pc_q, pc_d;
  logic [31:0]  hold_pc_q, hold_pc4_q, hold_instr_q;
  logic         push, pop, flush;
  logic [1:0]   count;
  fetch_entry_t head;
  fetch_entry_t entry_in;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_RUN;
      pc_q    <= RESET_PC;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
    end
  end

  // Push depends only on count, never on out_ready, so there is no
  // combinational path from decode back to the memory address.
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    push    = 1'b0;
    flush   = 1'b0;
    unique case (state_q)
      ST_RUN, ST_END: begin
        if (redirect_valid) begin
          flush = 1'b1;
          if (redirect_pc[1:0] != 2'b00) begin
            state_d = ST_FAULT;
          end else begin
            pc_d    = redirect_pc;
            state_d = ST_RUN;
          end
        end else if (state_q == ST_RUN) begin
          if (pc_q >= PC_LIMIT) begin
            state_d = ST_END;
          end else if (count != 2'(FETCH_BUF_DEPTH)) begin
            push = 1'b1;
            pc_d = pc_q + 32'(INSTR_BYTES);
          end
        end
      end
      default: ;
    endcase
  end

  assign entry_in = '{pc: pc_q, instr: imem_instr};

  fetch_buf2 u_buf (
    .clk     (clk),
    .rst_n   (rst_n),
    .push_i  (push),
    .pop_i   (pop),
    .flush_i (flush),
    .data_i  (entry_in),
    .count_o (count),
    .head_o  (head)
  );

  // Outputs keep showing the last presented entry while the buffer is empty.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hold_pc_q    <= '0;
      hold_pc4_q   <= '0;
      hold_instr_q <= '0;
    end else if (count != 2'd0) begin
      hold_pc_q    <= head.pc;
      hold_pc4_q   <= head.pc + 32'(INSTR_BYTES);
      hold_instr_q <= head.instr;
    end
  end

  assign out_valid = (state_q != ST_FAULT) && (count != 2'd0);
  assign pop       = out_valid && out_ready;
  assign out_pc    = out_valid ? head.pc : hold_pc_q;
  assign out_pc4   = out_valid ? head.pc + 32'(INSTR_BYTES) : hold_pc4_q;
  assign out_instr = out_valid ? head.instr : hold_instr_q;
  assign imem_addr = pc_q;
  assign halted    = (state_q == ST_END) && (count == 2'd0);
  assign fault     = (state_q == ST_FAULT);

endmodule

// File: tb/tb_imem_fetch_ctrl.sv
// Directed bench for imem_fetch_ctrl with a delivered-instruction scoreboard.
module tb_imem_fetch_ctrl;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] instr;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] imem_addr;
  logic [31:0] imem_instr;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_instr;
  logic [31:0] out_pc;
  logic [31:0] out_pc4;
  logic        halted;
  logic        fault;

  int   n_compared   = 0;
  int   n_mismatched = 0;
  exp_t exp_q[$];

  imem_fetch_ctrl #(.IMEM_WORDS(64), .RESET_PC(32'h0000_0000)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .imem_addr      (imem_addr),
    .imem_instr     (imem_instr),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .out_valid      (out_valid),
    .out_ready      (out_ready),
    .out_instr      (out_instr),
    .out_pc         (out_pc),
    .out_pc4        (out_pc4),
    .halted         (halted),
    .fault          (fault)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] instr_of(input logic [31:0] addr);
    logic [31:0] w;
    w = {26'd0, addr[7:2]};
    return 32'hA5C3_1000 ^ (w * 32'h0101_0043);
  endfunction

  always_comb begin
    imem_instr = (imem_addr < 32'd256) ? instr_of(imem_addr) : 32'hFFFF_FFFF;
  end

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_compared++;
    assert (obs === expv) else begin
      n_mismatched++;
      $error("FAIL %s: observed %h expected %h", tag, obs, expv);
    end
  endtask

  task automatic expect_pc(input logic [31:0] pc);
    exp_t e;
    e.pc    = pc;
    e.instr = instr_of(pc);
    exp_q.push_back(e);
  endtask

  // Scoreboard: every completed handshake must match the next expected entry.
  always @(negedge clk) begin
    if (rst_n && out_valid && out_ready) begin
      n_compared++;
      assert (exp_q.size() != 0) else begin
        n_mismatched++;
        $error("FAIL sb_unexpected: observed pc %h expected no transfer", out_pc);
      end
      if (exp_q.size() != 0) begin
        exp_t e;
        e = exp_q.pop_front();
        $display("xfer pc=%h instr=%h pc4=%h", out_pc, out_instr, out_pc4);
        chk("sb_pc", out_pc, e.pc);
        chk("sb_instr", out_instr, e.instr);
        chk("sb_pc4", out_pc4, e.pc + 32'd4);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL timeout: observed no finish expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    rst_n = 1'b0; out_ready = 1'b0; redirect_valid = 1'b0; redirect_pc = '0;
    step(2);
    chk("rst_addr", imem_addr, 32'h0);
    chk("rst_valid", 32'(out_valid), 32'd0);
    chk("rst_pc", out_pc, 32'h0);
    chk("rst_pc4", out_pc4, 32'h0);
    chk("rst_instr", out_instr, 32'h0);
    chk("rst_halted", 32'(halted), 32'd0);
    chk("rst_fault", 32'(fault), 32'd0);

    // Streaming with ready high: one instruction per cycle.
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) expect_pc(32'(i * 4));
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      step(1);
      chk("t1_valid", 32'(out_valid), 32'd1);
      chk("t1_pc", out_pc, 32'(i * 4));
    end
    step(1);
    rst_n = 1'b0;
    chk("t1_drained", 32'(exp_q.size()), 32'd0);

    // Backpressure: buffer fills, pc stalls, then drains without loss.
    step(1);
    out_ready = 1'b0;
    expect_pc(32'h0); expect_pc(32'h4); expect_pc(32'h8);
    rst_n = 1'b1;
    step(5);
    chk("t2_stall_addr", imem_addr, 32'h8);
    chk("t2_valid", 32'(out_valid), 32'd1);
    chk("t2_head", out_pc, 32'h0);
    out_ready = 1'b1;
    step(1);
    chk("t2_pop_pc", out_pc, 32'h4);
    chk("t2_nopush_addr", imem_addr, 32'h8);
    step(1);
    chk("t2_resume_pc", out_pc, 32'h8);
    chk("t2_resume_addr", imem_addr, 32'hC);
    step(1);
    rst_n = 1'b0;
    chk("t2_drained", 32'(exp_q.size()), 32'd0);

    // Redirect while 0x4 is being accepted.
    step(1);
    expect_pc(32'h0); expect_pc(32'h4); expect_pc(32'h20); expect_pc(32'h24);
    rst_n = 1'b1;
    step(1);
    chk("t3_pc0", out_pc, 32'h0);
    step(1);
    chk("t3_pc4", out_pc, 32'h4);
    redirect_valid = 1'b1; redirect_pc = 32'h20;
    step(1);
    redirect_valid = 1'b0;
    chk("t3_bubble", 32'(out_valid), 32'd0);
    chk("t3_addr", imem_addr, 32'h20);
    step(1);
    chk("t3_target_valid", 32'(out_valid), 32'd1);
    chk("t3_target_pc", out_pc, 32'h20);
    step(1);
    chk("t3_next_pc", out_pc, 32'h24);
    step(1);
    rst_n = 1'b0;
    chk("t3_drained", 32'(exp_q.size()), 32'd0);

    // Run to the end of memory, halt, then redirect back in.
    step(1);
    for (int i = 0; i < 64; i++) expect_pc(32'(i * 4));
    rst_n = 1'b1;
    step(64);
    chk("t4_last_pc", out_pc, 32'hFC);
    chk("t4_not_halted", 32'(halted), 32'd0);
    step(1);
    chk("t4_halted", 32'(halted), 32'd1);
    chk("t4_valid", 32'(out_valid), 32'd0);
    chk("t4_addr", imem_addr, 32'h100);
    chk("t4_hold_pc", out_pc, 32'hFC);
    step(2);
    chk("t4_still_halted", 32'(halted), 32'd1);
    expect_pc(32'h10); expect_pc(32'h14);
    redirect_valid = 1'b1; redirect_pc = 32'h10;
    step(1);
    redirect_valid = 1'b0;
    chk("t4_unhalt", 32'(halted), 32'd0);
    chk("t4_bubble", 32'(out_valid), 32'd0);
    step(1);
    chk("t4_resume_pc", out_pc, 32'h10);
    step(1);
    chk("t4_resume_next", out_pc, 32'h14);
    step(1);
    rst_n = 1'b0;
    chk("t4_drained", 32'(exp_q.size()), 32'd0);

    // Misaligned redirect faults; later redirects are ignored.
    step(1);
    expect_pc(32'h0);
    rst_n = 1'b1;
    step(1);
    chk("t5_pc0", out_pc, 32'h0);
    redirect_valid = 1'b1; redirect_pc = 32'h22;
    step(1);
    chk("t5_fault", 32'(fault), 32'd1);
    chk("t5_valid", 32'(out_valid), 32'd0);
    chk("t5_addr", imem_addr, 32'h4);
    redirect_pc = 32'h0;
    step(1);
    chk("t5_fault_sticky", 32'(fault), 32'd1);
    chk("t5_ignore_addr", imem_addr, 32'h4);
    chk("t5_ignore_valid", 32'(out_valid), 32'd0);
    redirect_valid = 1'b0;
    step(3);
    chk("t5_fault_hold", 32'(fault), 32'd1);
    chk("t5_valid_hold", 32'(out_valid), 32'd0);
    #2;
    rst_n = 1'b0;
    #1;
    chk("t5_fault_clr", 32'(fault), 32'd0);
    chk("t5_drained", 32'(exp_q.size()), 32'd0);

    // Asynchronous reset with the buffer full, between clock edges.
    out_ready = 1'b0;
    step(1);
    rst_n = 1'b1;
    step(3);
    chk("t6_full_valid", 32'(out_valid), 32'd1);
    chk("t6_full_addr", imem_addr, 32'h8);
    #2;
    rst_n = 1'b0;
    #1;
    chk("t6_async_valid", 32'(out_valid), 32'd0);
    chk("t6_async_addr", imem_addr, 32'h0);
    chk("t6_async_pc", out_pc, 32'h0);
    rst_n = 1'b1;
    step(1);
    chk("t6_first_push_valid", 32'(out_valid), 32'd1);
    chk("t6_first_push_pc", out_pc, 32'h0);
    chk("t6_first_push_addr", imem_addr, 32'h4);
    chk("t6_sb_empty", 32'(exp_q.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
    $finish;
  end

endmodule
